csa_pipelined_adder: RTL and testbench

Pipelined, parametrised carry-select adder/subtractor with a valid/ready stream interface. It is the successor of the fixed 5-block 32-bit carry-select adder. Differences from that adder:
- Uniform, parametrised block size.
- Pipeline registers inserted every `BLOCKS_PER_STAGE` blocks.
- Add/subtract mode with signed-overflow flag.
- Full backpressure.

It sits in the datapath wherever a wide adder must close timing at high clock rates and can tolerate `STAGES` cycles of latency.

---
 rtl/csa_pipelined_adder.sv | 187 ++++++++++++++++++
 tb/tb_csa_pipelined_adder.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/csa_pipelined_adder.sv
// -----------------------------------------------------------------------------
// csa_pipelined_adder
//
// Pipelined carry-select adder/subtractor with a valid/ready stream interface.
// The WIDTH-bit operands are split into NB = WIDTH/BLOCK blocks. Each pipeline
// stage evaluates BLOCKS_PER_STAGE consecutive blocks, so the pipeline has
// STAGES = NB/BLOCKS_PER_STAGE stages and a latency of STAGES cycles.
//
// Inside a stage the first block is a plain ripple-carry adder fed by the
// carry registered in the previous stage (stage 0: the input carry). Every
// further block precomputes both possible sums and selects one with the
// carry of the block below it.
//
// Subtraction is A + ~B + 1. The operand inversion and the forced carry-in
// are applied once, in front of stage 0.
//
// Handshake: a beat moves on an interface in a cycle where valid and ready
// are both high at the rising edge. The producer holds its payload stable
// while valid is high and ready is low. in_ready does not depend on
// in_valid. out_valid, S, Cout and V come straight from the last stage
// register. A single global stall (out_valid & ~out_ready) freezes every
// stage at once, so bubbles are not compressed.
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst_n      synchronous active-low reset; discards everything in flight
//   in_valid   operands present on A/B/Cin/Sub
//   in_ready   stage 0 accepts this cycle (low during reset and stall)
//   A, B       operands, WIDTH bits
//   Cin        carry in, ignored when Sub = 1
//   Sub        0: S = A + B + Cin, 1: S = A - B
//   out_valid  result present on S/Cout/V
//   out_ready  consumer accepts the result
//   S          sum/difference modulo 2^WIDTH
//   Cout       carry out of the MSB (for Sub, 1 means no borrow)
//   V          two's-complement overflow (carry into MSB xor Cout)
// -----------------------------------------------------------------------------
module csa_pipelined_adder #(
    parameter int WIDTH            = 32,
    parameter int BLOCK            = 8,
    parameter int BLOCKS_PER_STAGE = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             Sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             V
);

    localparam int NB     = WIDTH / BLOCK;
    localparam int STAGES = NB / BLOCKS_PER_STAGE;
    localparam int SW     = BLOCK * BLOCKS_PER_STAGE;   // bits per stage

    logic             stall;
    logic [WIDTH-1:0] bx;
    logic             c0;

    // Operand transform for subtraction; Cin is ignored when Sub = 1.
    assign bx = Sub ? ~B : B;
    assign c0 = Sub | Cin;

    assign stall    = out_valid & ~out_ready;
    assign in_ready = rst_n & ~stall;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SW;   // lowest bit owned by this stage

        // Stage inputs (from the ports for stage 0, else from stage k-1).
        logic [SW-1:0]             a_s;
        logic [SW-1:0]             b_s;
        logic                      c_in;
        logic                      v_in;
        logic [SW-1:0]             slice_sum;
        logic [BLOCKS_PER_STAGE:0] c;          // carry between blocks
        logic [LO+SW-1:0]          sum_next;

        // Stage register: valid, sum bits so far, carry out of this stage.
        logic                      valid_q;
        logic                      carry_q;
        logic [LO+SW-1:0]          sum_q;

        if (k == 0) begin : g_src
            assign a_s      = A[SW-1:0];
            assign b_s      = bx[SW-1:0];
            assign c_in     = c0;
            assign v_in     = in_valid;
            assign sum_next = slice_sum;
        end else begin : g_src
            assign a_s      = g_stage[k-1].g_ops.a_q[LO +: SW];
            assign b_s      = g_stage[k-1].g_ops.b_q[LO +: SW];
            assign c_in     = g_stage[k-1].carry_q;
            assign v_in     = g_stage[k-1].valid_q;
            assign sum_next = {slice_sum, g_stage[k-1].sum_q};
        end

        assign c[0] = c_in;

        for (genvar j = 0; j < BLOCKS_PER_STAGE; j++) begin : g_blk
            logic [BLOCK-1:0] a_b;
            logic [BLOCK-1:0] b_b;

            assign a_b = a_s[j*BLOCK +: BLOCK];
            assign b_b = b_s[j*BLOCK +: BLOCK];

            if (j == 0) begin : g_rca
                // Carry into this block is already settled (register or c0).
                logic [BLOCK:0] r;
                assign r = {1'b0, a_b} + {1'b0, b_b} + {{BLOCK{1'b0}}, c[0]};
                assign slice_sum[j*BLOCK +: BLOCK] = r[BLOCK-1:0];
                assign c[j+1] = r[BLOCK];
            end else begin : g_csel
                // Both outcomes are ready before the lower carry arrives.
                logic [BLOCK:0] r0;
                logic [BLOCK:0] r1;
                assign r0 = {1'b0, a_b} + {1'b0, b_b};
                assign r1 = {1'b0, a_b} + {1'b0, b_b} + {{BLOCK{1'b0}}, 1'b1};
                assign slice_sum[j*BLOCK +: BLOCK] = c[j] ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
                assign c[j+1] = c[j] ? r1[BLOCK] : r0[BLOCK];
            end
        end

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                valid_q <= 1'b0;
                carry_q <= 1'b0;
                sum_q   <= '0;
            end else if (!stall) begin
                valid_q <= v_in;
                carry_q <= c[BLOCKS_PER_STAGE];
                sum_q   <= sum_next;
            end
        end

        if (k < STAGES - 1) begin : g_ops
            // Operand slices not yet added travel alongside the partial sum.
            logic [WIDTH-1:LO+SW] a_up;
            logic [WIDTH-1:LO+SW] b_up;
            logic [WIDTH-1:LO+SW] a_q;
            logic [WIDTH-1:LO+SW] b_q;

            if (k == 0) begin : g_up
                assign a_up = A[WIDTH-1:SW];
                assign b_up = bx[WIDTH-1:SW];
            end else begin : g_up
                assign a_up = g_stage[k-1].g_ops.a_q[WIDTH-1:LO+SW];
                assign b_up = g_stage[k-1].g_ops.b_q[WIDTH-1:LO+SW];
            end

            // Pure datapath: contents are qualified by valid_q.
            always_ff @(posedge clk) begin
                if (!stall) begin
                    a_q <= a_up;
                    b_q <= b_up;
                end
            end
        end else begin : g_msb
            // The last stage owns the MSB, so the carry into it is recovered
            // from the MSB sum bit and its two operand bits.
            logic cmsb_next;
            logic cmsb_q;

            assign cmsb_next = slice_sum[SW-1] ^ a_s[SW-1] ^ b_s[SW-1];

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cmsb_q <= 1'b0;
                end else if (!stall) begin
                    cmsb_q <= cmsb_next;
                end
            end
        end
    end

    assign out_valid = g_stage[STAGES-1].valid_q;
    assign S         = g_stage[STAGES-1].sum_q;
    assign Cout      = g_stage[STAGES-1].carry_q;
    assign V         = g_stage[STAGES-1].g_msb.cmsb_q ^ g_stage[STAGES-1].carry_q;

endmodule

// File: tb/tb_csa_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_csa_pipelined_adder
//
// Directed bench for csa_pipelined_adder. The default 32-bit instance gets
// reset, hand-computed vectors, a backpressure stream and a reset during a
// stall. Two extra instances (16/4/1 and 64/16/4) get a random stream that
// is compared against a behavioural adder model.
// -----------------------------------------------------------------------------
module tb_csa_pipelined_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- default instance (32/8/2, 2 stages) ----------------
    logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, v;
    logic [31:0] a, b, s;

    csa_pipelined_adder #(.WIDTH(32), .BLOCK(8), .BLOCKS_PER_STAGE(2)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .A(a), .B(b), .Cin(cin), .Sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .S(s), .Cout(cout), .V(v)
    );

    // ---------------- 16/4/1 instance (4 stages) ----------------
    logic        iv16, ir16, ci16, sb16, ov16, cout16, v16;
    logic [15:0] a16, b16, s16;

    csa_pipelined_adder #(.WIDTH(16), .BLOCK(4), .BLOCKS_PER_STAGE(1)) dut16 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv16), .in_ready(ir16),
        .A(a16), .B(b16), .Cin(ci16), .Sub(sb16), .out_valid(ov16),
        .out_ready(1'b1), .S(s16), .Cout(cout16), .V(v16)
    );

    // ---------------- 64/16/4 instance (1 stage) ----------------
    logic        iv64, ir64, ci64, sb64, ov64, cout64, v64;
    logic [63:0] a64, b64, s64;

    csa_pipelined_adder #(.WIDTH(64), .BLOCK(16), .BLOCKS_PER_STAGE(4)) dut64 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv64), .in_ready(ir64),
        .A(a64), .B(b64), .Cin(ci64), .Sub(sb64), .out_valid(ov64),
        .out_ready(1'b1), .S(s64), .Cout(cout64), .V(v64)
    );

    // ---------------- scoreboard ----------------
    int tests  = 0;
    int failed = 0;
    logic [33:0] exp_q[$];
    logic [17:0] exp16_q[$];
    logic [65:0] exp64_q[$];

    task automatic check(input string tag, input logic [65:0] obs, input logic [65:0] want);
        tests++;
        assert (obs === want) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    // Reference models: {V, Cout, S}. Overflow uses the operand-sign rule.
    function automatic logic [33:0] model32(input logic [31:0] x, y, input logic ci, sb);
        logic [31:0] yx;
        logic [32:0] r;
        yx = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yx} + {32'd0, sb | ci};
        return {(x[31] == yx[31]) && (r[31] != x[31]), r[32], r[31:0]};
    endfunction

    function automatic logic [17:0] model16(input logic [15:0] x, y, input logic ci, sb);
        logic [15:0] yx;
        logic [16:0] r;
        yx = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yx} + {16'd0, sb | ci};
        return {(x[15] == yx[15]) && (r[15] != x[15]), r[16], r[15:0]};
    endfunction

    function automatic logic [65:0] model64(input logic [63:0] x, y, input logic ci, sb);
        logic [63:0] yx;
        logic [64:0] r;
        yx = sb ? ~y : y;
        r  = {1'b0, x} + {1'b0, yx} + {64'd0, sb | ci};
        return {(x[63] == yx[63]) && (r[63] != x[63]), r[64], r[63:0]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation through the default instance with out_ready high;
    // checks acceptance, 2-cycle latency and the hand-computed result.
    task automatic directed(input string tag, input logic [31:0] xa, xb,
                            input logic xc, xs, input logic [33:0] want);
        int n;
        out_ready = 1'b1;
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
        #1;
        check({tag, "_in_ready"}, in_ready, 1);
        tick();
        in_valid = 1'b0;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        n = 1;
        while (!out_valid && n < 10) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, n, 2);
        check({tag, "_result"}, {v, cout, s}, want);
    endtask

    // ---------------- directed sequence ----------------
    initial begin : main
        int          n_sent, cyc, first16, first64;
        logic        hold_valid, accept;
        logic [33:0] held;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        a = '0; b = '0; cin = 1'b0; sub = 1'b0;
        iv16 = 1'b0; a16 = '0; b16 = '0; ci16 = 1'b0; sb16 = 1'b0;
        iv64 = 1'b0; a64 = '0; b64 = '0; ci64 = 1'b0; sb64 = 1'b0;

        // Reset then idle.
        tick();
        check("rst_in_ready_1", in_ready, 0);
        tick();
        check("rst_in_ready_2", in_ready, 0);
        check("rst_outputs", {out_valid, v, cout, s}, 35'd0);
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", in_ready, 1);
        tick();
        check("idle_outputs", {out_valid, v, cout, s}, 35'd0);

        // Hand-computed vectors: {V, Cout, S}.
        directed("stage_carry", 32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, {2'b00, 32'h00010000});
        directed("full_wrap",   32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, {2'b01, 32'h00000000});
        directed("add_ovf",     32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, {2'b10, 32'h80000000});
        directed("sub_borrow",  32'h00000005, 32'h00000007, 1'b0, 1'b1, {2'b00, 32'hFFFFFFFE});
        directed("sub_ovf",     32'h80000000, 32'h00000001, 1'b0, 1'b1, {2'b11, 32'h7FFFFFFF});
        directed("sub_cin_ign", 32'h0000000A, 32'h00000003, 1'b1, 1'b1, {2'b01, 32'h00000007});
        directed("add_cin",     32'h12345678, 32'h11111111, 1'b1, 1'b0, {2'b00, 32'h2345678A});
        directed("neg_ovf",     32'h80000000, 32'h80000000, 1'b0, 1'b0, {2'b11, 32'h00000000});
        directed("sub_zero",    32'h00000000, 32'h00000000, 1'b0, 1'b1, {2'b01, 32'h00000000});
        tick();  // drain the last directed result
        check("drained", out_valid, 0);

        // Backpressure: 10 random ops, out_ready toggling randomly.
        n_sent = 0; cyc = 0; hold_valid = 1'b0; held = '0;
        while ((n_sent < 10 || exp_q.size() > 0) && cyc < 400) begin
            out_ready = 1'($urandom_range(0, 1));
            if (!in_valid && n_sent < 10) begin
                a = $urandom; b = $urandom;
                cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
                in_valid = 1'b1;
            end
            #1;
            if (hold_valid) check("bp_hold", {out_valid, v, cout, s}, {1'b1, held});
            check("bp_in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) check("bp_extra", 1, 0);
                else                   check("bp_result", {v, cout, s}, exp_q.pop_front());
            end
            hold_valid = out_valid && !out_ready;
            held       = {v, cout, s};
            accept     = in_valid && in_ready;
            if (accept) begin
                exp_q.push_back(model32(a, b, cin, sub));
                n_sent++;
            end
            @(posedge clk);
            #1;
            if (accept) in_valid = 1'b0;
            cyc++;
        end
        check("bp_sent", n_sent, 10);
        check("bp_left", exp_q.size(), 0);

        // Reset in the middle of a stall with two results in flight.
        out_ready = 1'b0;
        a = 32'd1; b = 32'd2; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
        tick();
        a = 32'd3; b = 32'd4;
        tick();
        in_valid = 1'b0;
        #1;
        check("ms_stalled", {out_valid, in_ready}, 2'b10);
        check("ms_first", {v, cout, s}, {2'b00, 32'd3});
        tick();
        check("ms_held", {out_valid, v, cout, s}, {3'b100, 32'd3});
        rst_n = 1'b0;
        #1;
        check("ms_rst_in_ready", in_ready, 0);
        tick();
        check("ms_rst_outputs", {out_valid, v, cout, s}, 35'd0);
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ms_no_stale", out_valid, 0);
        end

        // Configuration sweep: random streams against the models.
        first16 = -1; first64 = -1;
        for (int c = 0; c < 1010; c++) begin
            if (c < 1000) begin
                a16 = 16'($urandom); b16 = 16'($urandom);
                ci16 = 1'($urandom_range(0, 1)); sb16 = 1'($urandom_range(0, 1));
                iv16 = 1'b1;
                a64 = {$urandom, $urandom}; b64 = {$urandom, $urandom};
                ci64 = 1'($urandom_range(0, 1)); sb64 = 1'($urandom_range(0, 1));
                iv64 = 1'b1;
            end else begin
                iv16 = 1'b0; iv64 = 1'b0;
            end
            #1;
            if (ov16) begin
                if (first16 < 0) first16 = c;
                if (exp16_q.size() == 0) check("sw16_extra", 1, 0);
                else                     check("sw16_result", {v16, cout16, s16}, exp16_q.pop_front());
            end
            if (ov64) begin
                if (first64 < 0) first64 = c;
                if (exp64_q.size() == 0) check("sw64_extra", 1, 0);
                else                     check("sw64_result", {v64, cout64, s64}, exp64_q.pop_front());
            end
            if (iv16 && ir16) exp16_q.push_back(model16(a16, b16, ci16, sb16));
            if (iv64 && ir64) exp64_q.push_back(model64(a64, b64, ci64, sb64));
            tick();
        end
        check("sw16_latency", first16, 4);
        check("sw64_latency", first64, 1);
        check("sw16_left", exp16_q.size(), 0);
        check("sw64_left", exp64_q.size(), 0);

        // ---------------- final report ----------------
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    // Time limit: the directed sequence needs far fewer cycles than this.
    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout tests=%0d failed=%0d", tests, failed);
        $fatal(1, "watchdog");
    end

endmodule
